// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding, error codes
// and the byte-to-word packing ratio.
package imem_pkg;

    typedef logic [2:0] state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_SIZE   = 32;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_HI = 3'd1;
    localparam state_t ST_LEN_LO = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CSUM   = 3'd4;
    localparam state_t ST_DONE   = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte packer: the first byte lands in bits 31:24. word_valid_o
// pulses the cycle after the fourth byte, while word_o still holds that word.
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  index_o,
    output logic        word_valid_o
);

    logic [31:0] shreg_q;
    logic [1:0]  index_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= shift_i && !clear_i && (index_q == 2'(BYTES_PER_WORD - 1));
            if (clear_i) begin
                index_q <= '0;
            end else if (shift_i) begin
                shreg_q <= {shreg_q[23:0], byte_i};
                index_q <= index_q + 2'd1;
            end
        end
    end

    assign word_o       = shreg_q;
    assign index_o      = index_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: length, packed big-endian words, XOR checksum.
// Writes imem one word per pulse and releases the CPU only after a clean load.
module imem_loader
    import imem_pkg::*;
#(
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [15:0]           words_loaded
);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] words_q, words_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  errc_q, errc_d;

    logic        xfer;
    logic        packClear;
    logic        packShift;
    logic [31:0] packWord;
    logic [1:0]  packIndex;
    logic        packValid;
    logic [15:0] lenFull;

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (packClear),
        .shift_i      (packShift),
        .byte_i       (rx_data),
        .word_o       (packWord),
        .index_o      (packIndex),
        .word_valid_o (packValid)
    );

    assign rx_ready  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign xfer      = rx_valid && rx_ready;
    assign packShift = (state_q == ST_DATA) && xfer;
    assign lenFull   = {len_q[15:8], rx_data};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        csum_d    = csum_q;
        words_d   = words_q;
        hold_d    = hold_q;
        done_d    = done_q;
        error_d   = error_q;
        errc_d    = errc_q;
        packClear = 1'b0;

        // The write of the previous word is counted while the next word is still filling.
        if (packValid) begin
            words_d = words_q + 16'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_LEN_HI;
                    hold_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    errc_d    = ERR_NONE;
                    words_d   = '0;
                    csum_d    = '0;
                    packClear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = lenFull;
                    if ((lenFull == 16'd0) || (lenFull > 16'(SIZE))) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        errc_d  = ERR_LEN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ rx_data;
                    if ((packIndex == 2'(BYTES_PER_WORD - 1)) && (words_q + 16'd1 == len_q)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        errc_d  = ERR_CSUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            csum_q  <= '0;
            words_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            errc_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
            errc_q  <= errc_d;
        end
    end

    assign mem_we       = packValid;
    assign mem_addr     = {14'd0, words_q, 2'b00};
    assign mem_wdata    = DATA_WIDTH'(packWord);
    assign cpu_hold     = hold_q;
    assign busy         = rx_ready;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = errc_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good, bad-length, bad-checksum, max-length
// with stream gaps, and reset in the middle of a load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int          vecCount = 0;
    int          missCount = 0;
    int          logCount = 0;
    logic [31:0] logAddr [256];
    logic [31:0] logData [256];
    logic [31:0] frameWords [32];

    imem_loader #(.SIZE(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write-port monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (mem_we) begin
            if (logCount < 256) begin
                logAddr[logCount] = mem_addr;
                logData[logCount] = mem_wdata;
            end
            logCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int maxGap);
        int waitCycles;
        repeat ($urandom_range(0, maxGap)) @(negedge clk);
        rx_data    = b;
        rx_valid   = 1'b1;
        waitCycles = 0;
        while (!rx_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 50) checkOutput("rxReadyWait", 32'(waitCycles), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] len, input int nWords, input logic [7:0] csumFlip, input int maxGap);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        pulseStart();
        sendByte(len[15:8], maxGap);
        sendByte(len[7:0], maxGap);
        for (int w = 0; w < nWords; w++) begin
            for (int k = 0; k < 4; k++) begin
                b  = frameWords[w][31 - 8*k -: 8];
                cs = cs ^ b;
                sendByte(b, maxGap);
            end
        end
        if (nWords > 0) sendByte(cs ^ csumFlip, maxGap);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        logic [31:0] maxAddr;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("rstHold", 32'(cpu_hold), 32'd1);
        checkOutput("rstReady", 32'(rx_ready), 32'd0);
        checkOutput("rstWeCount", 32'(logCount), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstError", 32'(error), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstAddr", mem_addr, 32'd0);
        checkOutput("rstWdata", mem_wdata, 32'd0);

        $display("[TB] two-word good frame");
        frameWords[0] = 32'h8C010004;
        frameWords[1] = 32'h0000E000;
        base = logCount;
        applyStimulus(16'h0002, 2, 8'h00, 0);
        checkOutput("goodWeCount", 32'(logCount - base), 32'd2);
        checkOutput("goodAddr0", logAddr[base], 32'd0);
        checkOutput("goodData0", logData[base], 32'h8C010004);
        checkOutput("goodAddr1", logAddr[base+1], 32'd4);
        checkOutput("goodData1", logData[base+1], 32'h0000E000);
        checkOutput("goodDone", 32'(done), 32'd1);
        checkOutput("goodHold", 32'(cpu_hold), 32'd0);
        checkOutput("goodWords", 32'(words_loaded), 32'd2);
        checkOutput("goodBusy", 32'(busy), 32'd0);

        $display("[TB] oversize length");
        base = logCount;
        applyStimulus(16'h0021, 0, 8'h00, 0);
        checkOutput("lenError", 32'(error), 32'd1);
        checkOutput("lenCode", 32'(err_code), 32'd1);
        checkOutput("lenDoneClr", 32'(done), 32'd0);
        checkOutput("lenReady", 32'(rx_ready), 32'd0);
        checkOutput("lenWeCount", 32'(logCount - base), 32'd0);
        checkOutput("lenHold", 32'(cpu_hold), 32'd1);

        $display("[TB] bad checksum");
        frameWords[0] = 32'h0C000004;
        base = logCount;
        applyStimulus(16'h0001, 1, 8'h08, 0);
        checkOutput("csWeCount", 32'(logCount - base), 32'd1);
        checkOutput("csAddr0", logAddr[base], 32'd0);
        checkOutput("csData0", logData[base], 32'h0C000004);
        checkOutput("csError", 32'(error), 32'd1);
        checkOutput("csCode", 32'(err_code), 32'd2);
        checkOutput("csHold", 32'(cpu_hold), 32'd1);
        checkOutput("csWords", 32'(words_loaded), 32'd1);

        $display("[TB] 32-word load with gaps");
        for (int k = 0; k < 32; k++) begin
            frameWords[k] = {8'(k), 8'(k * 3 + 1), ~8'(k), 8'(k) ^ 8'h5A};
        end
        base = logCount;
        applyStimulus(16'h0020, 32, 8'h00, 3);
        checkOutput("maxWeCount", 32'(logCount - base), 32'd32);
        maxAddr = 32'd0;
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("maxAddr%0d", k), logAddr[base+k], 32'(4 * k));
            checkOutput($sformatf("maxData%0d", k), logData[base+k], frameWords[k]);
            if (logAddr[base+k] > maxAddr) maxAddr = logAddr[base+k];
        end
        checkOutput("maxTopAddr", maxAddr, 32'd124);
        checkOutput("maxDone", 32'(done), 32'd1);
        checkOutput("maxWords", 32'(words_loaded), 32'd32);

        $display("[TB] reset mid-load");
        frameWords[0] = 32'h8C010004;
        frameWords[1] = 32'h0000E000;
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        for (int k = 0; k < 6; k++) begin
            sendByte(frameWords[k / 4][31 - 8*(k % 4) -: 8], 0);
        end
        checkOutput("midBusy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midRstHold", 32'(cpu_hold), 32'd1);
        checkOutput("midRstReady", 32'(rx_ready), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        base = logCount;
        applyStimulus(16'h0002, 2, 8'h00, 1);
        checkOutput("rerunWeCount", 32'(logCount - base), 32'd2);
        checkOutput("rerunData1", logData[base+1], 32'h0000E000);
        checkOutput("rerunDone", 32'(done), 32'd1);
        checkOutput("rerunHold", 32'(cpu_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
